// File: rtl/pps_emu_pkg.sv
// Shared FSM type, LFSR constants and width helper for the PPS emulator.
package pps_emu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PULSE
  } state_t;

  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pps_emu_lfsr.sv
// Jitter source for the PPS emulator: 16-bit Galois LFSR stepped once per advance strobe.
module pps_emu_lfsr
  import pps_emu_pkg::*;
#(
  parameter int JitterBits = 3
) (
  input  logic                  clk_tf,
  input  logic                  tf_reset,
  input  logic                  advance,
  output logic [JitterBits-1:0] jitter
);

  logic [15:0] shift_reg;

  always_ff @(posedge clk_tf or posedge tf_reset) begin
    if (tf_reset) begin
      shift_reg <= LFSR_SEED;
    end else if (advance) begin
      shift_reg <= (shift_reg >> 1) ^ (shift_reg[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign jitter = shift_reg[JitterBits-1:0];

endmodule

// File: rtl/pps_emulator.sv
// Self-test PPS source: free-running one-second counter, programmable pulse phase, pulse-drop injection.
// Define PPS_EMU_JITTER_EN to dither the pulse position per second with an LFSR.
module pps_emulator
  import pps_emu_pkg::*;
#(
  parameter  int ClocksPerSecond = 10000,
  parameter  int PulseWidth      = 20,
  parameter  int JitterBits      = 3,
  localparam int CW              = cnt_width(ClocksPerSecond)
) (
  input  logic          clk_tf,
  input  logic          tf_reset,
  input  logic          enable,
  input  logic [CW-1:0] phase_offset,
  input  logic          phase_load,
  input  logic          skip_next,
  output logic          pps_raw_logic,
  output logic          epoch,
  output logic          pulse_start,
  output logic          pulse_skipped
);

  localparam int            WW        = cnt_width(PulseWidth);
  localparam logic [CW-1:0] LastTick  = CW'(ClocksPerSecond - 1);
  localparam logic [WW-1:0] WidthLoad = WW'(PulseWidth - 1);

  state_t        state;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] phase_pending;
  logic [CW-1:0] phase_active;
  logic [CW-1:0] phase_clamped;
  logic [CW-1:0] phase_next;
  logic [CW-1:0] match_pos;
  logic [WW-1:0] width_cnt;
  logic          skip_flag;
  logic          wrap;
  logic          match;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    phase_clamped = (phase_offset > LastTick) ? LastTick : phase_offset;
    phase_next    = phase_load ? phase_clamped : phase_pending;
  end

  assign wrap  = (sec_cnt == LastTick);
  assign match = (sec_cnt == match_pos);

  // Phase changes only land at the wrap, so each second sees exactly one match position.
  always_ff @(posedge clk_tf or posedge tf_reset) begin
    if (tf_reset) begin
      sec_cnt       <= '0;
      epoch         <= 1'b0;
      phase_pending <= '0;
      phase_active  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      sec_cnt <= wrap ? '0 : sec_cnt + 1'b1;
      epoch   <= wrap;
      if (phase_load) phase_pending <= phase_clamped;
      if (wrap)       phase_active  <= phase_next;
    end
  end

`ifdef PPS_EMU_JITTER_EN
  localparam logic signed [CW+1:0] CpsSigned = (CW+2)'(ClocksPerSecond);

  logic [JitterBits-1:0] jitter;
  logic signed [CW+1:0]  jit_sum;

  pps_emu_lfsr #(.JitterBits(JitterBits)) u_lfsr (
    .clk_tf  (clk_tf),
    .tf_reset(tf_reset),
    .advance (epoch),
    .jitter  (jitter)
  );

  always_comb begin
    jit_sum = $signed({2'b00, phase_next}) + (CW+2)'($signed(jitter));
    if (jit_sum < 0) begin
      jit_sum = jit_sum + CpsSigned;
    end else if (jit_sum >= CpsSigned) begin
      jit_sum = jit_sum - CpsSigned;
    end
  end

  always_ff @(posedge clk_tf or posedge tf_reset) begin
    if (tf_reset) begin
      match_pos <= '0;
    end else if (wrap) begin
      match_pos <= jit_sum[CW-1:0];
    end
  end
`else
  assign match_pos = phase_active;
`endif

  always_ff @(posedge clk_tf or posedge tf_reset) begin
    if (tf_reset) begin
      state         <= IDLE;
      width_cnt     <= '0;
      skip_flag     <= 1'b0;
      pps_raw_logic <= 1'b0;
      pulse_start   <= 1'b0;
      pulse_skipped <= 1'b0;
    end else begin
      pulse_start   <= 1'b0;
      pulse_skipped <= 1'b0;
      if (skip_next) skip_flag <= 1'b1;
      unique case (state)
        IDLE: begin
          if (enable) state <= ARMED;
        end
        ARMED: begin
          if (match) begin
            if (skip_flag) begin
              // A strobe landing on the consuming match re-arms the skip for next second.
              if (!skip_next) skip_flag <= 1'b0;
              pulse_skipped <= 1'b1;
            end else begin
              state         <= PULSE;
              width_cnt     <= WidthLoad;
              pps_raw_logic <= 1'b1;
              pulse_start   <= 1'b1;
            end
          end else if (!enable) begin
            state <= IDLE;
          end
        end
        PULSE: begin
          if (width_cnt == '0) begin
            pps_raw_logic <= 1'b0;
            state         <= enable ? ARMED : IDLE;
          end else begin
            width_cnt <= width_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pps_emulator.sv
// Directed bench for pps_emulator: two instances run independent scenarios on a shared clock.
module tb_pps_emulator;

  localparam int Cps = 10000;
  localparam int Cw  = 14;

  logic          clk_tf = 1'b0;
  logic          tf_reset      [2];
  logic          enable        [2];
  logic [Cw-1:0] phase_offset  [2];
  logic          phase_load    [2];
  logic          skip_next     [2];
  logic          pps           [2];
  logic          epoch         [2];
  logic          pulse_start   [2];
  logic          pulse_skipped [2];

  always #5 clk_tf = ~clk_tf;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pps_emulator #(
      .ClocksPerSecond(Cps),
      .PulseWidth     (20),
      .JitterBits     (3)
    ) dut (
      .clk_tf       (clk_tf),
      .tf_reset     (tf_reset[g]),
      .enable       (enable[g]),
      .phase_offset (phase_offset[g]),
      .phase_load   (phase_load[g]),
      .skip_next    (skip_next[g]),
      .pps_raw_logic(pps[g]),
      .epoch        (epoch[g]),
      .pulse_start  (pulse_start[g]),
      .pulse_skipped(pulse_skipped[g])
    );
  end

  int cyc     = 0;
  bit running = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  int rise_q  [2][$];
  int width_q [2][$];
  int skip_q  [2][$];
  int high_len  [2] = '{0, 0};
  bit pps_d     [2] = '{1'b0, 1'b0};
  int start_err [2] = '{0, 0};
  int epoch_err [2] = '{0, 0};

  // Cycle number n = posedges since reset release; the second counter is then n mod Cps.
  always @(posedge clk_tf) if (running) cyc++;

  always @(negedge clk_tf) begin
    if (running) begin
      for (int i = 0; i < 2; i++) begin
        if (pps[i] === 1'b1 && !pps_d[i]) rise_q[i].push_back(cyc);
        if (pps[i] !== 1'b1 && pps_d[i])  width_q[i].push_back(high_len[i]);
        high_len[i] = (pps[i] === 1'b1) ? high_len[i] + 1 : 0;
        if (pulse_start[i] !== ((pps[i] === 1'b1) && !pps_d[i])) start_err[i]++;
        if (epoch[i] !== (!tf_reset[i] && cyc > 0 && (cyc % Cps) == 0)) epoch_err[i]++;
        if (pulse_skipped[i] === 1'b1) skip_q[i].push_back(cyc);
        pps_d[i] = (pps[i] === 1'b1);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_list(input string tag, input int got[$], input int exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      check($sformatf("%s[%0d]", tag, k), (k < got.size()) ? got[k] : -1, exp[k]);
    end
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) @(negedge clk_tf);
  endtask

  task automatic load_phase(input int i, input int value);
    phase_offset[i] = Cw'(value);
    phase_load[i]   = 1'b1;
    @(negedge clk_tf);
    phase_load[i]   = 1'b0;
  endtask

  task automatic strobe_skip(input int i);
    skip_next[i] = 1'b1;
    @(negedge clk_tf);
    skip_next[i] = 1'b0;
  endtask

  // Instance 0: phase 0 for three seconds, wrap-cycle load of 300, mid-second load of 500, async reset.
  // Instance 1: phase 9990 straddling the wrap, double skip, enable drop mid-pulse, clamped 12000.
  int exp_rise_a  [$] = '{10001, 20001, 30001, 40301, 50501};
  int exp_width_a [$] = '{20, 20, 20, 20, 5};
  int exp_rise_b  [$] = '{19991, 29991, 49991, 70000};
  int exp_width_b [$] = '{20, 20, 20, 20};
  int exp_skip_b  [$] = '{39991};
  int empty_q     [$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      tf_reset[i]     = 1'b1;
      enable[i]       = 1'b1;
      phase_offset[i] = '0;
      phase_load[i]   = 1'b0;
      skip_next[i]    = 1'b0;
    end
    repeat (3) @(negedge clk_tf);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_pps%0d", i),     pps[i],           1'b0);
      check($sformatf("reset_epoch%0d", i),   epoch[i],         1'b0);
      check($sformatf("reset_start%0d", i),   pulse_start[i],   1'b0);
      check($sformatf("reset_skipped%0d", i), pulse_skipped[i], 1'b0);
    end
    tf_reset[0] = 1'b0;
    tf_reset[1] = 1'b0;
    running     = 1'b1;

    at_cycle(100);
    load_phase(1, 9990);
    at_cycle(30100);
    strobe_skip(1);
    at_cycle(30200);
    strobe_skip(1);
    at_cycle(39999);
    load_phase(0, 300);
    at_cycle(44000);
    load_phase(0, 500);
    at_cycle(45000);
    load_phase(1, 12000);
    at_cycle(49995);
    enable[1] = 1'b0;
    at_cycle(50005);
    check("b_no_runt_across_wrap", pps[1], 1'b1);

    at_cycle(50505);
    check("a_high_before_reset", pps[0], 1'b1);
    #2 tf_reset[0] = 1'b1;
    #1 check("a_async_reset_drop", pps[0], 1'b0);
    check("a_async_reset_start", pulse_start[0], 1'b0);

    at_cycle(55000);
    check("b_idle_after_drop", pps[1], 1'b0);
    at_cycle(60100);
    enable[1] = 1'b1;
    at_cycle(70100);

    check_list("a_rise",    rise_q[0],  exp_rise_a);
    check_list("a_width",   width_q[0], exp_width_a);
    check_list("a_skipped", skip_q[0],  empty_q);
    check_list("b_rise",    rise_q[1],  exp_rise_b);
    check_list("b_width",   width_q[1], exp_width_b);
    check_list("b_skipped", skip_q[1],  exp_skip_b);
    check("a_start_align", start_err[0], 0);
    check("b_start_align", start_err[1], 0);
    check("a_epoch_align", epoch_err[0], 0);
    check("b_epoch_align", epoch_err[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
